// File: rtl/mul_pipe_pkg.sv
// Shared encodings and defaults for the pipelined multiplier.
// Optional flush feature is enabled with `define MUL_PIPE_FLUSH_EN.
package mul_pipe_pkg;
   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_MUL   = 2'd1,
      OP_MAC   = 2'd2,
      OP_RDCLR = 2'd3
   } op_e;

   localparam int SIGN_SRC0  = 0;
   localparam int SIGN_SRC1  = 1;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 3;
endpackage

// File: rtl/mul_core.sv
// Combinational multiply with per-operand signedness, 2*WIDTH result.
// Pipeline registers around it are retimed by synthesis.
module mul_core
   import mul_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]   src0_i,
   input  logic [WIDTH-1:0]   src1_i,
   input  logic [1:0]         sign_i,
   output logic [2*WIDTH-1:0] prod_o
);
   logic              s0;
   logic              s1;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;

   assign s0 = sign_i[SIGN_SRC0] & src0_i[WIDTH-1];
   assign s1 = sign_i[SIGN_SRC1] & src1_i[WIDTH-1];

   // Low 2*WIDTH bits of an extended product equal the exact signed product.
   assign a_ext  = {{WIDTH{s0}}, src0_i};
   assign b_ext  = {{WIDTH{s1}}, src1_i};
   assign prod_o = a_ext * b_ext;
endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined multiplier / MAC with valid-ready handshake and global stall.
// `define MUL_PIPE_FLUSH_EN adds a flush port that kills in-flight ops.
module mul_pipe_unit
   import mul_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_src0,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [1:0]       in_op,
   input  logic [1:0]       in_sign,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef MUL_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res0,
   output logic [WIDTH-1:0] out_res1
);
   localparam int DW = 2 * WIDTH;

   logic [DW-1:0]     prod;
   logic              adv;
   logic              kill;
   logic              accept;
   op_e               op_in;

   logic [STAGES-1:0] vld_q, vld_d;
   op_e               op_q[STAGES];
   op_e               op_d[STAGES];
   logic [DW-1:0]     prod_q[STAGES];
   logic [DW-1:0]     prod_d[STAGES];
   logic [DW-1:0]     acc_q, acc_d;
   logic [DW-1:0]     res_q, res_d;
   logic              ovld_q, ovld_d;
   logic [DW-1:0]     sum;

   mul_core #(.WIDTH(WIDTH)) u_core (
      .src0_i (in_src0),
      .src1_i (in_src1),
      .sign_i (in_sign),
      .prod_o (prod)
   );

`ifdef MUL_PIPE_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   assign op_in    = op_e'(in_op);
   assign adv      = !ovld_q | out_ready;
   assign in_ready = reset & adv & !kill;
   assign accept   = in_valid & in_ready;
   assign sum      = acc_q + prod_q[STAGES-1];

   always_comb begin
      vld_d  = vld_q;
      op_d   = op_q;
      prod_d = prod_q;
      acc_d  = acc_q;
      res_d  = res_q;
      ovld_d = ovld_q;
      if (adv) begin
         vld_d[0]  = accept && (op_in != OP_NOP);
         op_d[0]   = op_in;
         prod_d[0] = prod;
         for (int i = 1; i < STAGES; i++) begin
            vld_d[i]  = vld_q[i-1];
            op_d[i]   = op_q[i-1];
            prod_d[i] = prod_q[i-1];
         end
         ovld_d = vld_q[STAGES-1];
         res_d  = '0;
         if (vld_q[STAGES-1]) begin
            unique case (op_q[STAGES-1])
               OP_MAC: begin
                  res_d = sum;
                  acc_d = sum;
               end
               OP_RDCLR: begin
                  res_d = acc_q;
                  acc_d = '0;
               end
               OP_MUL:  res_d = prod_q[STAGES-1];
               OP_NOP:  res_d = '0;
            endcase
         end
      end
      // A killed op at the last stage must not reach the accumulator.
      if (kill) begin
         vld_d  = '0;
         ovld_d = 1'b0;
         res_d  = '0;
         acc_d  = acc_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_q  <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         ovld_q <= 1'b0;
         for (int i = 0; i < STAGES; i++) begin
            op_q[i]   <= OP_NOP;
            prod_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         op_q   <= op_d;
         prod_q <= prod_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
         ovld_q <= ovld_d;
      end
   end

   assign out_valid = ovld_q;
   assign out_res0  = res_q[WIDTH-1:0];
   assign out_res1  = res_q[DW-1:WIDTH];
endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit (WIDTH=32, STAGES=3).
// Flush scenario is built only with `define MUL_PIPE_FLUSH_EN.
module tb_mul_pipe_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] in_src0, in_src1;
   logic [1:0]  in_op, in_sign;
   logic        in_valid, in_ready;
   logic        out_valid, out_ready;
   logic [31:0] out_res0, out_res1;
`ifdef MUL_PIPE_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int nvec = 0;
   int nerr = 0;

   logic [1:0]  s_op[16];
   logic [1:0]  s_sg[16];
   logic [31:0] s_a[16];
   logic [31:0] s_b[16];
   logic [63:0] s_exp[16];

   always #5 clock = ~clock;

   mul_pipe_unit #(.WIDTH(32), .STAGES(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_src0   (in_src0),
      .in_src1   (in_src1),
      .in_op     (in_op),
      .in_sign   (in_sign),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MUL_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res0  (out_res0),
      .out_res1  (out_res1)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mul1(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sg, input logic [63:0] exp,
                       input string tag);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 2'd1;
      in_sign   = sg;
      in_src0   = a;
      in_src1   = b;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
      step();
      chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_res"}, {out_res1, out_res0}, exp);
      step();
      chk({tag, "_drain"}, {out_res1, out_res0, out_valid} == 65'd0
          ? 64'd0 : 64'd1, 64'd0);
   endtask

   task automatic run_stream(input int n, input int nexp, input int stall,
                             input string tag);
      int sent = 0;
      int got = 0;
      int scnt = 0;
      bit seen = 0;
      bit rchk = 0;
      for (int c = 0; c < 60 && got < nexp; c++) begin
         if (out_valid && !seen) begin
            seen = 1;
            scnt = stall;
         end
         out_ready = (scnt == 0);
         if (scnt > 0) scnt--;
         in_valid = (sent < n);
         if (sent < n) begin
            in_op   = s_op[sent];
            in_sign = s_sg[sent];
            in_src0 = s_a[sent];
            in_src1 = s_b[sent];
         end
         #1;
         if (out_valid && !out_ready && !rchk) begin
            rchk = 1;
            chk({tag, "_stall_rdy"}, {63'd0, in_ready}, 64'd0);
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk($sformatf("%s_%0d", tag, got), {out_res1, out_res0},
                s_exp[got]);
            got++;
         end
         @(posedge clock);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_count"}, 64'(got), 64'(nexp));
   endtask

   task automatic set_op(input int i, input logic [1:0] op,
                         input logic [1:0] sg, input logic [31:0] a,
                         input logic [31:0] b);
      s_op[i] = op;
      s_sg[i] = sg;
      s_a[i]  = a;
      s_b[i]  = b;
   endtask

   initial begin
      bit stale;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_sign   = 2'd0;
      in_src0   = '0;
      in_src1   = '0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_vld", {63'd0, out_valid}, 64'd0);
      chk("rst_res", {out_res1, out_res0}, 64'd0);
      chk("rst_rdy", {63'd0, in_ready}, 64'd0);
      reset = 1'b1;
      #1;
      chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);

      mul1(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFFFFFFFE_00000001, "uu");
      mul1(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'hFFFFFFFF_00000001, "su");
      mul1(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF_00000001, "us");
      mul1(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'h00000000_00000001, "ss");
      mul1(32'h80000000, 32'h80000000, 2'b11, 64'h40000000_00000000, "minmin");
      mul1(32'h12345678, 32'h00000010, 2'b00, 64'h00000001_23456780, "shift");

      for (int i = 0; i < 6; i++) begin
         set_op(i, 2'd1, 2'b00, 32'(i + 1), 32'd10);
         s_exp[i] = 64'((i + 1) * 10);
      end
      run_stream(6, 6, 4, "stream");

      set_op(0, 2'd3, 2'b00, 32'd9, 32'd9);
      set_op(1, 2'd2, 2'b00, 32'd3, 32'd4);
      set_op(2, 2'd0, 2'b00, 32'd7, 32'd7);
      set_op(3, 2'd2, 2'b00, 32'd5, 32'd6);
      set_op(4, 2'd3, 2'b00, 32'd0, 32'd0);
      set_op(5, 2'd2, 2'b00, 32'd1, 32'd1);
      set_op(6, 2'd2, 2'b11, 32'hFFFFFFFF, 32'd2);
      set_op(7, 2'd3, 2'b00, 32'd0, 32'd0);
      s_exp[0] = 64'd0;
      s_exp[1] = 64'd12;
      s_exp[2] = 64'd42;
      s_exp[3] = 64'd42;
      s_exp[4] = 64'd1;
      s_exp[5] = 64'hFFFFFFFF_FFFFFFFF;
      s_exp[6] = 64'hFFFFFFFF_FFFFFFFF;
      run_stream(8, 7, 0, "mac");

      set_op(0, 2'd2, 2'b00, 32'd7, 32'd1);
      s_exp[0] = 64'd7;
      run_stream(1, 1, 0, "preload");
      in_valid = 1'b1;
      in_op    = 2'd2;
      in_src0  = 32'd7;
      in_src1  = 32'd1;
      step();
      in_op   = 2'd1;
      in_src0 = 32'd2;
      in_src1 = 32'd2;
      step();
      in_valid = 1'b0;
      reset    = 1'b0;
      step();
      chk("mrst_vld", {63'd0, out_valid}, 64'd0);
      chk("mrst_res", {out_res1, out_res0}, 64'd0);
      chk("mrst_rdy", {63'd0, in_ready}, 64'd0);
      reset = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (out_valid) stale = 1;
      end
      chk("mrst_stale", {63'd0, stale}, 64'd0);
      set_op(0, 2'd3, 2'b00, 32'd0, 32'd0);
      s_exp[0] = 64'd0;
      run_stream(1, 1, 0, "mrst_acc");

`ifdef MUL_PIPE_FLUSH_EN
      set_op(0, 2'd2, 2'b00, 32'd5, 32'd1);
      s_exp[0] = 64'd5;
      run_stream(1, 1, 0, "fl_pre");
      in_valid = 1'b1;
      in_op    = 2'd2;
      in_src0  = 32'd2;
      in_src1  = 32'd2;
      step();
      in_op = 2'd1;
      step();
      step();
      in_valid = 1'b0;
      flush    = 1'b1;
      #1;
      chk("fl_rdy", {63'd0, in_ready}, 64'd0);
      step();
      flush = 1'b0;
      chk("fl_vld", {63'd0, out_valid}, 64'd0);
      chk("fl_res", {out_res1, out_res0}, 64'd0);
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (out_valid) stale = 1;
      end
      chk("fl_stale", {63'd0, stale}, 64'd0);
      set_op(0, 2'd3, 2'b00, 32'd0, 32'd0);
      set_op(1, 2'd1, 2'b00, 32'd2, 32'd3);
      s_exp[0] = 64'd5;
      s_exp[1] = 64'd6;
      run_stream(2, 2, 0, "fl_post");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
